image_port_arbiter: RTL
=======================

IMAGE_PORT_ARBITER -- requirements
Module: image_port_arbiter

Interface
REQ-001 SHALL have parameter N_CORES, default 4: number of requesting logic cores (2..8).
REQ-002 SHALL have parameter A_W, default 5: image memory address width.
REQ-003 SHALL have parameter D_W, default 1: pixel data width.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port REQ, input, N_CORES bits: per-core access request.
REQ-007 SHALL have port WR, input, N_CORES bits: per-core access type, 1 = write, 0 = read.
REQ-008 SHALL have port ADDR, input, N_CORES*A_W bits: per-core address; core i uses slice [i*A_W +: A_W].
REQ-009 SHALL have port WDATA, input, N_CORES*D_W bits: per-core write data; core i uses slice [i*D_W +: D_W].
REQ-010 SHALL have port GNT, output, N_CORES bits: one-cycle, one-hot grant pulse.
REQ-011 SHALL have port RDATA, output, D_W bits: read data, broadcast to all cores.
REQ-012 SHALL have port RVALID, output, N_CORES bits: one-hot read-data-valid pulse.
REQ-013 SHALL have port BUSY, output, 1 bit: high when state is not IDLE.
REQ-014 SHALL have port M_A, output, A_W bits: memory exchange-port address.
REQ-015 SHALL have port M_DI, output, D_W bits: memory exchange-port write data.
REQ-016 SHALL have port M_WE, output, 1 bit: memory exchange-port write enable.
REQ-017 SHALL have port M_DQ, input, D_W bits: memory exchange-port read data, combinational from M_A.

Function
REQ-018 SHALL implement states IDLE, GRANT and COMMIT.
REQ-019 In IDLE with any REQ bit high, SHALL select one core round-robin, starting at last-granted+1 modulo N_CORES.
REQ-020 At that selection edge, SHALL latch the selected core's index, WR, ADDR slice and WDATA slice, and go to GRANT.
REQ-021 In IDLE with REQ all zero, SHALL stay in IDLE with M_WE=0.
REQ-022 In GRANT, SHALL drive M_A=latched address and GNT[sel]=1, and update the last-granted pointer to sel.
REQ-023 GRANT read: M_WE=0; M_DQ captured into RDATA at the GRANT end edge; RVALID[sel]=1 for one cycle after GRANT; GRANT then goes to IDLE.
REQ-024 GRANT write: M_WE=1; GRANT then goes to COMMIT.
REQ-025 In COMMIT, SHALL drive M_WE=0, hold M_A, and drive M_DI=latched data; the memory commits at the COMMIT end edge because it registers address and enable but samples data in the following cycle. COMMIT then goes to IDLE.
REQ-026 M_DI SHALL always equal the latched data register, and M_A SHALL always equal the latched address register.
REQ-027 A read grant SHALL occupy 2 cycles, IDLE plus GRANT; a write grant SHALL occupy 3 cycles, IDLE plus GRANT plus COMMIT.
REQ-028 The IDLE cycle after COMMIT SHALL be the read-after-write bubble, so any read issued afterwards returns the committed value.
REQ-029 Requesters SHALL hold REQ, WR, ADDR and WDATA until their GNT cycle inclusive; a REQ still high in the next IDLE SHALL be treated as a new request.
REQ-030 REQ changes during GRANT or COMMIT SHALL be ignored; the latched request SHALL not be altered.
REQ-031 With simultaneous requests, exactly one GNT bit SHALL be high, and no core SHALL wait more than N_CORES-1 grants.
REQ-032 The pointer SHALL wrap from N_CORES-1 to 0.

Reset
REQ-033 While RST is high at a rising edge, SHALL go to IDLE and set GNT=0, RVALID=0, RDATA=0, M_WE=0, M_A=0, latched data=0 (so M_DI=0), BUSY=0, and last-granted=N_CORES-1 so core 0 wins first.
REQ-034 RST asserted in a write GRANT cycle SHALL result in 0 being written to the latched address in the next cycle; this is defined behaviour, because the memory has already registered the enable.
REQ-035 RST asserted in COMMIT SHALL still let the write complete with the latched data.

Structure
REQ-036 SHALL put default A_W, D_W and N_CORES values and the state encoding (IDLE=0, GRANT=1, COMMIT=2) in shared package image_mem_pkg.
REQ-037 SHALL place round-robin selection in a combinational sub-module rr_arbiter (inputs REQ and pointer; outputs one-hot pick and index).

Verification
REQ-038 Reset then REQ=0001, WR=0, ADDR0=4 -> GNT=0001 on cycle 2, RVALID=0001 on cycle 3, RDATA=1 (initial image pixel 4).
REQ-039 REQ=0010, WR=0010, ADDR1=9, WDATA1=1 -> GNT=0010, M_WE=1 in GRANT, M_DI=1 in COMMIT; a following read of 9 returns 1.
REQ-040 REQ=1111 held continuously, all reads -> grant order 0,1,2,3,0 with no core repeated before all are served.
REQ-041 Core 2 writes 0 to address 12, core 3 reads 12 in the same cycle; pointer=1 -> core 2 granted first, core 3 reads 0.
REQ-042 RST in write GRANT to address 5 -> BUSY=0 next cycle, address 5 reads 0; RST in COMMIT -> the latched value is stored.
REQ-043 Pointer=3 with REQ=1001 -> core 0 granted (wrap-around).

Source files
------------

// File: rtl/image_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_mem_pkg
// Description : Shared defaults and state encoding for the image memory
//               port arbiter and its round-robin selector.
// Revision    : 1.0 - initial release
// ============================================================================
package image_mem_pkg;

    localparam int c_N_CORES = 4;   // default number of requesting cores
    localparam int c_A_W     = 5;   // default image memory address width
    localparam int c_D_W     = 1;   // default pixel data width

    // Arbiter state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_GRANT  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Searches the request
//               vector starting at the core after the last-granted pointer
//               and wrapping modulo N_CORES.
// Ports       : i_req  - per-core request vector
//               i_ptr  - index of the last-granted core
//               o_pick - one-hot selected core (all zero when no request)
//               o_idx  - index of the selected core
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import image_mem_pkg::*;
#(
    parameter int N_CORES = c_N_CORES,
    parameter int IDX_W   = (c_N_CORES > 1) ? $clog2(c_N_CORES) : 1
) (
    input  logic [N_CORES-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [N_CORES-1:0] o_pick,
    output logic [IDX_W-1:0]   o_idx
);

    // One extra bit so ptr + step (at most 2*N_CORES-1) never overflows
    localparam logic [IDX_W:0] c_N = (IDX_W+1)'(N_CORES);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        // Step k = N_CORES lands back on the pointer itself, so the
        // last-granted core is considered only after every other core.
        for (int k = 1; k <= N_CORES; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found        = 1'b1;
                o_idx          = w_cand;
                o_pick[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/image_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : image_port_arbiter
// Description : Shares one image memory exchange port among N_CORES logic
//               cores. A read takes IDLE+GRANT, a write IDLE+GRANT+COMMIT;
//               the memory registers address/enable and samples data one
//               cycle later, so write data is presented during COMMIT.
// Ports       : CLK, RST      - clock, synchronous active-high reset
//               REQ, WR       - per-core request and access type (1 = write)
//               ADDR, WDATA   - per-core packed address / write data slices
//               GNT, RVALID   - one-hot grant and read-valid pulses
//               RDATA         - read data broadcast to all cores
//               BUSY          - high whenever a transaction is in flight
//               M_A, M_DI,
//               M_WE, M_DQ    - memory exchange port
// Revision    : 1.0 - initial release
// ============================================================================
module image_port_arbiter
    import image_mem_pkg::*;
#(
    parameter int N_CORES = c_N_CORES,
    parameter int A_W     = c_A_W,
    parameter int D_W     = c_D_W
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_CORES-1:0]     REQ,
    input  logic [N_CORES-1:0]     WR,
    input  logic [N_CORES*A_W-1:0] ADDR,
    input  logic [N_CORES*D_W-1:0] WDATA,
    output logic [N_CORES-1:0]     GNT,
    output logic [D_W-1:0]         RDATA,
    output logic [N_CORES-1:0]     RVALID,
    output logic                   BUSY,
    output logic [A_W-1:0]         M_A,
    output logic [D_W-1:0]         M_DI,
    output logic                   M_WE,
    input  logic [D_W-1:0]         M_DQ
);

    localparam int c_IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_sel;
    logic [c_IDX_W-1:0] r_last;
    logic               r_wr;
    logic [A_W-1:0]     r_addr;
    logic [D_W-1:0]     r_data;
    logic [N_CORES-1:0] r_gnt;
    logic [N_CORES-1:0] r_rvalid;
    logic [D_W-1:0]     r_rdata;
    logic               r_we;

    logic [N_CORES-1:0] w_pick;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_wr;
    logic [A_W-1:0]     w_addr;
    logic [D_W-1:0]     w_wdata;

    rr_arbiter #(
        .N_CORES (N_CORES),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .i_req  (REQ),
        .i_ptr  (r_last),
        .o_pick (w_pick),
        .o_idx  (w_idx)
    );

    // One-hot mux of the selected core's request fields
    always_comb begin
        w_wr    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (w_pick[i]) begin
                w_wr    = WR[i];
                w_addr  = ADDR[i*A_W +: A_W];
                w_wdata = WDATA[i*D_W +: D_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // Clearing r_data here is what makes a reset during a write
            // GRANT commit zero: the memory has already taken the enable.
            r_state  <= c_ST_IDLE;
            r_sel    <= '0;
            r_last   <= c_IDX_W'(N_CORES-1);
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_we     <= 1'b0;
        end else begin
            r_rvalid <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (|REQ) begin
                        r_sel   <= w_idx;
                        r_wr    <= w_wr;
                        r_addr  <= w_addr;
                        r_data  <= w_wdata;
                        r_gnt   <= w_pick;
                        r_we    <= w_wr;
                        r_state <= c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
                    r_gnt  <= '0;
                    r_we   <= 1'b0;
                    r_last <= r_sel;
                    if (r_wr) begin
                        r_state <= c_ST_COMMIT;
                    end else begin
                        r_rdata  <= M_DQ;
                        r_rvalid <= r_gnt;
                        r_state  <= c_ST_IDLE;
                    end
                end
                c_ST_COMMIT: begin
                    // Memory samples M_DI (= r_data) at the end of this cycle
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign GNT    = r_gnt;
    assign RVALID = r_rvalid;
    assign RDATA  = r_rdata;
    assign BUSY   = (r_state != c_ST_IDLE);
    assign M_A    = r_addr;
    assign M_DI   = r_data;
    assign M_WE   = r_we;

endmodule
`default_nettype wire
